// File: rtl/instr_decode_stage.sv
// Registered decode stage for the 16-bit ISA with a 2-entry skid buffer (output reg + skid reg).
// Decoded fields are derived from the raw word held in the output register.
module instr_decode_stage #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [15:0]           in_instr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            opcode,
   output logic [3:0]            rdest,
   output logic [3:0]            rsrc,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  imm_sel,
   output logic                  wEnable,
   output logic                  flags_we,
   output logic                  illegal,
   output logic [CNT_W-1:0]      issued_count
);

   logic             out_valid_q;
   logic [15:0]      out_instr_q;
   logic             skid_valid_q;
   logic [15:0]      skid_instr_q;
   logic [CNT_W-1:0] count_q;

   logic accept;
   logic pop;

   assign in_ready     = ~skid_valid_q;
   assign out_valid    = out_valid_q;
   assign issued_count = count_q;
   assign accept       = in_valid & in_ready;
   assign pop          = out_valid_q & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_instr_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         count_q      <= '0;
      end else if (flush) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         if (pop) begin
            count_q <= count_q + 1'b1;
         end
         if (!out_valid_q || out_ready) begin
            // Output slot frees up: the older skid entry has priority over the input.
            if (skid_valid_q) begin
               out_instr_q  <= skid_instr_q;
               out_valid_q  <= 1'b1;
               skid_valid_q <= 1'b0;
            end else begin
               out_valid_q <= accept;
               if (accept) begin
                  out_instr_q <= in_instr;
               end
            end
         end else if (accept) begin
            skid_instr_q <= in_instr;
            skid_valid_q <= 1'b1;
         end
      end
   end

   logic [3:0] op;
   logic [3:0] ext;
   logic [7:0] imm8;

   assign op    = out_instr_q[15:12];
   assign ext   = out_instr_q[7:4];
   assign imm8  = out_instr_q[7:0];
   assign rdest = out_instr_q[11:8];
   assign rsrc  = out_instr_q[3:0];

   always_comb begin
      opcode   = {op, 4'h0};
      imm      = '0;
      imm_sel  = 1'b0;
      wEnable  = 1'b0;
      flags_we = 1'b0;
      illegal  = 1'b0;
      unique case (op)
         4'h0: begin
            opcode   = {op, ext};
            wEnable  = (ext != 4'hB) && (ext != 4'h0);
            flags_we = ext inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE};
         end
         4'h1, 4'h2, 4'h3, 4'h4: illegal = 1'b1;
         4'h5, 4'h7, 4'h9, 4'hA, 4'hE: begin
            imm_sel  = 1'b1;
            wEnable  = 1'b1;
            flags_we = 1'b1;
            imm      = DATA_WIDTH'($signed(imm8));
         end
         4'hB: begin
            imm_sel  = 1'b1;
            flags_we = 1'b1;
            imm      = DATA_WIDTH'($signed(imm8));
         end
         4'h6: begin
            imm_sel  = 1'b1;
            wEnable  = 1'b1;
            flags_we = 1'b1;
            imm      = DATA_WIDTH'(imm8);
         end
         4'hD: begin
            imm_sel = 1'b1;
            wEnable = 1'b1;
            imm     = DATA_WIDTH'(imm8);
         end
         4'h8, 4'hC, 4'hF: begin
            imm_sel = 1'b1;
            wEnable = 1'b1;
            imm     = DATA_WIDTH'(out_instr_q[3:0]);
         end
      endcase
   end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized and directed checks of instr_decode_stage against a queue-based reference model.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [15:0] in_instr;

   logic        in_ready, out_valid, imm_sel, wEnable, flags_we, illegal;
   logic [7:0]  opcode;
   logic [3:0]  rdest, rsrc;
   logic [15:0] imm;
   logic [15:0] issued_count;

   logic        c4_in_ready, c4_out_valid, c4_imm_sel, c4_wEnable, c4_flags_we, c4_illegal;
   logic [7:0]  c4_opcode;
   logic [3:0]  c4_rdest, c4_rsrc;
   logic [15:0] c4_imm;
   logic [3:0]  c4_count;

   instr_decode_stage #(.DATA_WIDTH(16), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
      .rdest(rdest), .rsrc(rsrc), .imm(imm), .imm_sel(imm_sel), .wEnable(wEnable),
      .flags_we(flags_we), .illegal(illegal), .issued_count(issued_count)
   );

   instr_decode_stage #(.DATA_WIDTH(16), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c4_in_ready),
      .in_instr(in_instr), .out_valid(c4_out_valid), .out_ready(out_ready), .opcode(c4_opcode),
      .rdest(c4_rdest), .rsrc(c4_rsrc), .imm(c4_imm), .imm_sel(c4_imm_sel),
      .wEnable(c4_wEnable), .flags_we(c4_flags_we), .illegal(c4_illegal),
      .issued_count(c4_count)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [15:0] q[$];
   int unsigned mcount = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected decode straight from the ISA tables.
   function automatic void ref_decode(input logic [15:0] w, output logic [7:0] opc,
                                      output logic [15:0] im, output logic isel,
                                      output logic we, output logic fwe, output logic ill);
      logic [3:0] o;
      logic [3:0] e;
      o    = w[15:12];
      e    = w[7:4];
      opc  = {o, 4'h0};
      im   = 16'h0;
      isel = 1'b0;
      we   = 1'b0;
      fwe  = 1'b0;
      ill  = 1'b0;
      if (o == 4'h0) begin
         opc = {4'h0, e};
         we  = !(e inside {4'h0, 4'hB});
         fwe = e inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE};
      end else if (o inside {4'h1, 4'h2, 4'h3, 4'h4}) begin
         ill = 1'b1;
      end else begin
         isel = 1'b1;
         we   = (o != 4'hB);
         fwe  = o inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hE};
         if (o inside {4'h6, 4'hD}) im = {8'h00, w[7:0]};
         else if (o inside {4'h8, 4'hC, 4'hF}) im = {12'h000, w[3:0]};
         else im = {{8{w[7]}}, w[7:0]};
      end
   endfunction

   task automatic compare_state();
      logic [7:0]  e_opc;
      logic [15:0] e_imm;
      logic        e_isel, e_we, e_fwe, e_ill;
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      check("count", issued_count, mcount % 65536);
      check("count4", c4_count, mcount % 16);
      if (q.size() > 0) begin
         ref_decode(q[0], e_opc, e_imm, e_isel, e_we, e_fwe, e_ill);
         check("opcode", opcode, e_opc);
         check("rdest", rdest, q[0][11:8]);
         check("rsrc", rsrc, q[0][3:0]);
         check("imm", imm, e_imm);
         check("imm_sel", imm_sel, e_isel);
         check("wEnable", wEnable, e_we);
         check("flags_we", flags_we, e_fwe);
         check("illegal", illegal, e_ill);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic v, input logic [15:0] w, input logic r, input logic f);
      int n;
      compare_state();
      in_valid  = v;
      in_instr  = w;
      out_ready = r;
      flush     = f;
      @(posedge clk);
      n = q.size();
      if (f) begin
         q.delete();
      end else begin
         if (n > 0 && r) begin
            void'(q.pop_front());
            mcount++;
         end
         if (v && n < 2) q.push_back(w);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_count", issued_count, 16'h0);
      check("rst_count4", c4_count, 4'h0);
      q.delete();
      mcount = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] bp_words[4];
      int          idx;
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_instr  = 16'h0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Directed decode examples
      step(1'b1, 16'h53FE, 1'b1, 1'b0);
      check("addi_opcode", opcode, 8'h50);
      check("addi_rdest", rdest, 4'h3);
      check("addi_imm", imm, 16'hFFFE);
      check("addi_imm_sel", imm_sel, 1'b1);
      check("addi_we", wEnable, 1'b1);
      check("addi_fwe", flags_we, 1'b1);
      step(1'b1, 16'h61FE, 1'b1, 1'b0);
      check("addui_imm", imm, 16'h00FE);
      step(1'b1, 16'h02B4, 1'b1, 1'b0);
      check("cmp_opcode", opcode, 8'h0B);
      check("cmp_we", wEnable, 1'b0);
      check("cmp_fwe", flags_we, 1'b1);
      step(1'b1, 16'h1234, 1'b1, 1'b0);
      check("ill_illegal", illegal, 1'b1);
      check("ill_we", wEnable, 1'b0);
      step(1'b0, 16'h0, 1'b1, 1'b0);

      // Backpressure: 3 stalled cycles, then drain in order
      do_reset();
      bp_words = '{16'h5101, 16'h0252, 16'hD3A3, 16'hC404};
      idx = 0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) check("bp_in_ready", in_ready, 1'b0);
         if (q.size() < 2 && idx < 4) begin
            step(1'b1, bp_words[idx], 1'b0, 1'b0);
            idx++;
         end else begin
            step(1'b1, bp_words[idx], 1'b0, 1'b0);
         end
      end
      for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
         if (idx < 4) begin
            if (q.size() < 2) begin
               step(1'b1, bp_words[idx], 1'b1, 1'b0);
               idx++;
            end else begin
               step(1'b1, bp_words[idx], 1'b1, 1'b0);
            end
         end else begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
         end
      end
      check("bp_count", issued_count, 16'd4);
      check("bp_drained", out_valid, 1'b0);

      // Flush with both entries full, input valid and output ready
      do_reset();
      step(1'b1, 16'h5111, 1'b0, 1'b0);
      step(1'b1, 16'h6222, 1'b0, 1'b0);
      step(1'b1, 16'h7333, 1'b1, 1'b1);
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      check("flush_count", issued_count, 16'h0);

      // 17 back-to-back handshakes; 4-bit counter wraps to 1
      do_reset();
      for (int c = 0; c < 18; c++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
      check("wrap_count4", c4_count, 4'h1);
      check("wrap_count16", issued_count, 16'd17);
      step(1'b0, 16'h0, 1'b1, 1'b0);

      // Random traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 31) == 0);
      end

      // Asynchronous reset while an entry is held
      step(1'b1, 16'h5001, 1'b0, 1'b0);
      check("pre_reset_valid", out_valid, 1'b1);
      do_reset();
      compare_state();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
